clock_mode_ctrl: RTL and testbench

Top-level mode controller for the digital clock ASIC. It converts the two raw user buttons into clean press events and selects which functional block owns them: time display, time set, alarm set or stop watch. It drives the per-block enables, forwards single-cycle button pulses only to the active block, and returns to time display on that block's ack flag, a long-press abort or an inactivity timeout.

---
 rtl/clock_pkg.sv | 38 +++
 rtl/clock_mode_ctrl_if.sv | 33 +++
 rtl/clock_mode_ctrl_btn_event.sv | 77 +++++++
 rtl/clock_mode_ctrl.sv | 131 +++++++++++++
 tb/tb_clock_mode_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: encodings shared between the mode controller and the display mux.
//   mode_e - value driven on mode_state (which block owns the buttons)
//   menu_e - value driven on menu_sel (pending selection while in CLOCK)
// Helpers map a menu entry to its mode and advance the menu cyclically.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK      = 2'd0,
    MODE_TIME_SET   = 2'd1,
    MODE_ALARM_SET  = 2'd2,
    MODE_STOP_WATCH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    MENU_TIME_SET   = 2'd0,
    MENU_ALARM_SET  = 2'd1,
    MENU_STOP_WATCH = 2'd2
  } menu_e;

  // An unused encoding maps to CLOCK so a corrupted menu can never enable a block.
  function automatic mode_e menu_to_mode(input menu_e m);
    case (m)
      MENU_TIME_SET:   return MODE_TIME_SET;
      MENU_ALARM_SET:  return MODE_ALARM_SET;
      MENU_STOP_WATCH: return MODE_STOP_WATCH;
      default:         return MODE_CLOCK;
    endcase
  endfunction

  function automatic menu_e next_menu(input menu_e m);
    case (m)
      MENU_TIME_SET:  return MENU_ALARM_SET;
      MENU_ALARM_SET: return MENU_STOP_WATCH;
      default:        return MENU_TIME_SET;
    endcase
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: button, tick, ack and mode-output bundle of the mode controller.
//   master - the environment side (drives tick, raw buttons and acks)
//   slave  - the controller side (drives mode_state, menu_sel, enables, pulses)
interface clock_mode_ctrl_if;
  logic       tick_1hz;
  logic       mode_btn_raw;
  logic       inc_btn_raw;
  logic       time_set_ack_flag;
  logic       alarm_set_ack_flag;
  logic       stop_watch_ack_flag;
  logic [1:0] mode_state;
  logic [1:0] menu_sel;
  logic       time_set_en;
  logic       alarm_set_en;
  logic       stop_watch_en;
  logic       mode_button;
  logic       inc_button;
  logic       abort_pulse;

  modport master (
    output tick_1hz, mode_btn_raw, inc_btn_raw,
    output time_set_ack_flag, alarm_set_ack_flag, stop_watch_ack_flag,
    input  mode_state, menu_sel, time_set_en, alarm_set_en, stop_watch_en,
    input  mode_button, inc_button, abort_pulse
  );

  modport slave (
    input  tick_1hz, mode_btn_raw, inc_btn_raw,
    input  time_set_ack_flag, alarm_set_ack_flag, stop_watch_ack_flag,
    output mode_state, menu_sel, time_set_en, alarm_set_en, stop_watch_en,
    output mode_button, inc_button, abort_pulse
  );
endinterface

// File: rtl/clock_mode_ctrl_btn_event.sv
// btn_event: turns one synchronised, debounced button level into registered
// single-cycle events, each visible the cycle after the causing sample.
//   clk, rst  - system clock, synchronous active-high reset
//   btn       - button level
//   press_evt - rising edge
//   short_evt - release after fewer than HOLD_CYCLES held samples
//   long_evt  - once, on the sample where the hold count reaches HOLD_CYCLES
//   rep_evt   - every REPEAT_CYCLES while held past HOLD_CYCLES
// Build option: CLOCK_MODE_AUTOREPEAT_EN enables rep_evt; otherwise it is
// tied low and REPEAT_CYCLES has no effect. HOLD_CYCLES must be >= 2.
module btn_event #(
  parameter int HOLD_CYCLES   = 2000,
  parameter int REPEAT_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_evt,
  output logic short_evt,
  output logic long_evt,
  output logic rep_evt
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          btn_q;
  logic [HW-1:0] hold_cnt;

  // hold_cnt is the number of consecutive high samples, saturating at HOLD_MAX,
  // so a release seen with hold_cnt == HOLD_MAX follows a long press and is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= 1'b0;
      hold_cnt  <= '0;
      press_evt <= 1'b0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
    end else begin
      btn_q     <= btn;
      press_evt <= btn & ~btn_q;
      short_evt <= ~btn & btn_q & (hold_cnt < HOLD_MAX);
      long_evt  <= btn & (hold_cnt == HOLD_LAST);
      if (!btn)
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef CLOCK_MODE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
      rep_evt <= 1'b0;
    end else if (!btn || hold_cnt != HOLD_MAX) begin
      rep_cnt <= '0;
      rep_evt <= 1'b0;
    end else if (rep_cnt == REP_LAST) begin
      rep_cnt <= '0;
      rep_evt <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
      rep_evt <= 1'b0;
    end
  end
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  assign rep_evt = 1'b0;
`endif

endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: top-level mode controller of the digital clock.
// Cleans the mode/inc buttons into events, lets the user pick a block from a
// menu in CLOCK, enables that block, forwards button pulses only to it and
// returns to CLOCK on its ack, a long mode press (abort) or an idle timeout.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - clock_mode_ctrl_if.slave: tick_1hz, raw buttons, ack flags in;
//              mode_state, menu_sel, enables, mode/inc pulses, abort_pulse out
// Build option: CLOCK_MODE_AUTOREPEAT_EN adds inc auto-repeat in TIME_SET and
// ALARM_SET.
//
// state           | meaning
// MODE_CLOCK      | time display; mode cycles menu_sel, inc enters the selection
// MODE_TIME_SET   | time-set block owns the buttons; idle timeout active
// MODE_ALARM_SET  | alarm-set block owns the buttons; idle timeout active
// MODE_STOP_WATCH | stop-watch block owns the buttons; never times out
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2000,
  parameter int IDLE_TIMEOUT  = 30,
  parameter int REPEAT_CYCLES = 500
) (
  input logic clk,
  input logic rst,
  clock_mode_ctrl_if.slave bus
);
  localparam bit IDLE_ON     = (IDLE_TIMEOUT > 0);
  localparam int IW          = IDLE_ON ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int IDLE_LAST_I = IDLE_ON ? IDLE_TIMEOUT - 1 : 0;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LAST_I);

  logic mode_press, mode_short, mode_long, mode_rep;
  logic inc_press, inc_short, inc_long, inc_rep;

  btn_event #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_mode_evt (
    .clk(clk), .rst(rst), .btn(bus.mode_btn_raw),
    .press_evt(mode_press), .short_evt(mode_short), .long_evt(mode_long), .rep_evt(mode_rep)
  );

  btn_event #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc_evt (
    .clk(clk), .rst(rst), .btn(bus.inc_btn_raw),
    .press_evt(inc_press), .short_evt(inc_short), .long_evt(inc_long), .rep_evt(inc_rep)
  );

  // Only the mode button's short/long and the inc button's press/repeat matter.
  logic unused_evt;
  assign unused_evt = &{1'b0, mode_press, mode_rep, inc_short, inc_long, inc_rep};

  mode_e         state;
  menu_e         menu;
  logic [IW-1:0] idle_cnt;
  logic          ts_en, as_en, sw_en;

  logic  own_ack, active, timed, inc_fwd, any_evt, idle_hit;
  mode_e target;

  always_comb begin
    own_ack = 1'b0;
    case (state)
      MODE_TIME_SET:   own_ack = bus.time_set_ack_flag;
      MODE_ALARM_SET:  own_ack = bus.alarm_set_ack_flag;
      MODE_STOP_WATCH: own_ack = bus.stop_watch_ack_flag;
      default:         own_ack = 1'b0;
    endcase
  end

  assign active = (state != MODE_CLOCK);
  assign timed  = (state == MODE_TIME_SET) || (state == MODE_ALARM_SET);
  assign target = menu_to_mode(menu);

`ifdef CLOCK_MODE_AUTOREPEAT_EN
  assign inc_fwd = inc_press | (inc_rep & timed);
`else
  assign inc_fwd = inc_press;
`endif

  assign any_evt  = mode_short | mode_long | inc_fwd;
  // A button event on the final tick restarts the idle window instead of exiting.
  assign idle_hit = IDLE_ON && timed && bus.tick_1hz && (idle_cnt == IDLE_LAST) && !any_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MODE_CLOCK;
      menu     <= MENU_TIME_SET;
      idle_cnt <= '0;
      ts_en    <= 1'b0;
      as_en    <= 1'b0;
      sw_en    <= 1'b0;
    end else begin
      case (state)
        MODE_CLOCK: begin
          idle_cnt <= '0;
          if (inc_press) begin
            state <= target;
            ts_en <= (target == MODE_TIME_SET);
            as_en <= (target == MODE_ALARM_SET);
            sw_en <= (target == MODE_STOP_WATCH);
          end else if (mode_short) begin
            menu <= next_menu(menu);
          end
        end
        default: begin
          if (own_ack || mode_long || idle_hit) begin
            state    <= MODE_CLOCK;
            idle_cnt <= '0;
            ts_en    <= 1'b0;
            as_en    <= 1'b0;
            sw_en    <= 1'b0;
          end else if (any_evt) begin
            idle_cnt <= '0;
          end else if (IDLE_ON && timed && bus.tick_1hz) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Pulses are gated straight off the registered events so they appear in the
  // event's own cycle; an ack in that cycle wins and swallows the event.
  assign bus.mode_button = active & ~own_ack & mode_short;
  assign bus.inc_button  = active & ~own_ack & ~mode_long & inc_fwd;
  assign bus.abort_pulse = active & ~own_ack & mode_long;

  assign bus.mode_state    = state;
  assign bus.menu_sel      = menu;
  assign bus.time_set_en   = ts_en;
  assign bus.alarm_set_en  = as_en;
  assign bus.stop_watch_en = sw_en;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;
  localparam int HOLD   = 8;
  localparam int IDLE_T = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(.HOLD_CYCLES(HOLD), .IDLE_TIMEOUT(IDLE_T), .REPEAT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  int cnt_mb, cnt_ib, cnt_ab, last_ab;

  // Reference model: press lengths as plain integers, mode as 0..3.
  // e_* are the events the controller acts on during the current cycle.
  int md_hold, m_mode, m_menu, m_idle;
  bit md_prev, in_prev, e_short, e_long, e_inc, m_own;

  always @(posedge clk) begin
    if (rst) begin
      md_hold = 0; md_prev = 0; in_prev = 0;
      e_short = 0; e_long = 0; e_inc = 0;
      m_mode = 0; m_menu = 0; m_idle = 0;
    end else begin
      m_own = (m_mode == 1 && bus.time_set_ack_flag) || (m_mode == 2 && bus.alarm_set_ack_flag) ||
              (m_mode == 3 && bus.stop_watch_ack_flag);
      if (m_mode == 0) begin
        if (e_inc) begin
          m_mode = m_menu + 1;
          m_idle = 0;
        end else if (e_short) m_menu = (m_menu + 1) % 3;
      end else if (m_own || e_long) begin
        m_mode = 0;
      end else if (e_short || e_inc) begin
        m_idle = 0;
      end else if (bus.tick_1hz && m_mode != 3) begin
        m_idle++;
        if (m_idle == IDLE_T) m_mode = 0;
      end
      e_inc   = bus.inc_btn_raw && !in_prev;
      e_short = !bus.mode_btn_raw && md_prev && (md_hold < HOLD);
      e_long  = bus.mode_btn_raw && (md_hold + 1 == HOLD);
      md_hold = bus.mode_btn_raw ? md_hold + 1 : 0;
      md_prev = bus.mode_btn_raw;
      in_prev = bus.inc_btn_raw;
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc_no++;
      if (bus.mode_button === 1'b1) cnt_mb++;
      if (bus.inc_button === 1'b1) cnt_ib++;
      if (bus.abort_pulse === 1'b1) begin cnt_ab++; last_ab = cyc_no; end
    end
  endtask

  task automatic clear_counts();
    cnt_mb = 0; cnt_ib = 0; cnt_ab = 0; last_ab = -1;
  endtask

  task automatic press_mode(input int len);
    bus.mode_btn_raw = 1'b1; run(len);
    bus.mode_btn_raw = 1'b0; run(4);
  endtask

  task automatic press_inc(input int len);
    bus.inc_btn_raw = 1'b1; run(len);
    bus.inc_btn_raw = 1'b0; run(4);
  endtask

  task automatic pulse_tick();
    bus.tick_1hz = 1'b1; run(1);
    bus.tick_1hz = 1'b0; run(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; run(3);
    rst = 1'b0; clear_counts(); run(20);
    n_cmp++; if (bus.mode_state !== 2'd0) begin n_bad++; $display("FAIL reset_mode got=%0d exp=0", bus.mode_state); end
    n_cmp++; if (bus.menu_sel !== 2'd0) begin n_bad++; $display("FAIL reset_menu got=%0d exp=0", bus.menu_sel); end
    n_cmp++; if ({bus.time_set_en, bus.alarm_set_en, bus.stop_watch_en} !== 3'b000) begin
      n_bad++; $display("FAIL reset_en got=%b exp=000", {bus.time_set_en, bus.alarm_set_en, bus.stop_watch_en}); end
    n_cmp++; if (cnt_mb + cnt_ib + cnt_ab !== 0) begin n_bad++; $display("FAIL reset_pulses got=%0d exp=0", cnt_mb + cnt_ib + cnt_ab); end
  endtask

  task automatic test_menu_enter();
    clear_counts();
    press_mode(2);
    n_cmp++; if (bus.menu_sel !== 2'd1) begin n_bad++; $display("FAIL menu_first got=%0d exp=1", bus.menu_sel); end
    press_mode(2);
    n_cmp++; if (bus.menu_sel !== 2'd2) begin n_bad++; $display("FAIL menu_second got=%0d exp=2", bus.menu_sel); end
    press_inc(2);
    n_cmp++; if (bus.mode_state !== 2'd3) begin n_bad++; $display("FAIL enter_sw_mode got=%0d exp=3", bus.mode_state); end
    n_cmp++; if (bus.stop_watch_en !== 1'b1) begin n_bad++; $display("FAIL enter_sw_en got=%b exp=1", bus.stop_watch_en); end
    n_cmp++; if (cnt_ib !== 0 || cnt_mb !== 0) begin n_bad++; $display("FAIL clock_pulse_free got inc=%0d mode=%0d exp 0/0", cnt_ib, cnt_mb); end
  endtask

  task automatic test_stop_watch();
    clear_counts();
    repeat (3) press_mode(2);
    n_cmp++; if (cnt_mb !== 3) begin n_bad++; $display("FAIL sw_mode_pulses got=%0d exp=3", cnt_mb); end
    bus.stop_watch_ack_flag = 1'b1; run(1);
    n_cmp++; if (bus.mode_state !== 2'd0) begin n_bad++; $display("FAIL sw_ack_mode got=%0d exp=0", bus.mode_state); end
    n_cmp++; if (bus.stop_watch_en !== 1'b0) begin n_bad++; $display("FAIL sw_ack_en got=%b exp=0", bus.stop_watch_en); end
    bus.stop_watch_ack_flag = 1'b0; run(2);
  endtask

  task automatic test_abort();
    int c0;
    press_mode(2);
    press_inc(2);
    n_cmp++; if (bus.mode_state !== 2'd1 || bus.time_set_en !== 1'b1) begin
      n_bad++; $display("FAIL enter_ts got mode=%0d en=%b exp 1/1", bus.mode_state, bus.time_set_en); end
    clear_counts();
    c0 = cyc_no;
    bus.mode_btn_raw = 1'b1; run(12);
    bus.mode_btn_raw = 1'b0; run(4);
    n_cmp++; if (cnt_ab !== 1) begin n_bad++; $display("FAIL abort_count got=%0d exp=1", cnt_ab); end
    n_cmp++; if (last_ab - c0 !== HOLD) begin n_bad++; $display("FAIL abort_cycle got=%0d exp=%0d", last_ab - c0, HOLD); end
    n_cmp++; if (cnt_mb !== 0) begin n_bad++; $display("FAIL abort_release_pulse got=%0d exp=0", cnt_mb); end
    n_cmp++; if (bus.mode_state !== 2'd0 || bus.time_set_en !== 1'b0) begin
      n_bad++; $display("FAIL abort_exit got mode=%0d en=%b exp 0/0", bus.mode_state, bus.time_set_en); end
  endtask

  task automatic test_idle_timeout();
    press_mode(2);
    press_inc(2);
    n_cmp++; if (bus.mode_state !== 2'd2 || bus.alarm_set_en !== 1'b1) begin
      n_bad++; $display("FAIL enter_as got mode=%0d en=%b exp 2/1", bus.mode_state, bus.alarm_set_en); end
    clear_counts();
    pulse_tick(); pulse_tick();
    n_cmp++; if (bus.mode_state !== 2'd2) begin n_bad++; $display("FAIL idle_early got=%0d exp=2", bus.mode_state); end
    pulse_tick();
    n_cmp++; if (bus.mode_state !== 2'd0 || cnt_ab !== 0) begin
      n_bad++; $display("FAIL idle_exit got mode=%0d abort=%0d exp 0/0", bus.mode_state, cnt_ab); end
    press_inc(2);
    clear_counts();
    pulse_tick(); pulse_tick();
    press_inc(2);
    n_cmp++; if (cnt_ib !== 1) begin n_bad++; $display("FAIL idle_inc_fwd got=%0d exp=1", cnt_ib); end
    pulse_tick(); pulse_tick();
    n_cmp++; if (bus.mode_state !== 2'd2) begin n_bad++; $display("FAIL idle_restart got=%0d exp=2", bus.mode_state); end
    pulse_tick();
    n_cmp++; if (bus.mode_state !== 2'd0) begin n_bad++; $display("FAIL idle_exit2 got=%0d exp=0", bus.mode_state); end
  endtask

  task automatic test_ack_collision();
    press_mode(2);
    press_inc(2);
    n_cmp++; if (bus.mode_state !== 2'd3) begin n_bad++; $display("FAIL enter_sw2 got=%0d exp=3", bus.mode_state); end
    bus.inc_btn_raw = 1'b1;
    @(negedge clk);
    bus.stop_watch_ack_flag = 1'b1;
    #1;
    n_cmp++; if (bus.inc_button !== 1'b0) begin n_bad++; $display("FAIL ack_drop_inc got=%b exp=0", bus.inc_button); end
    run(1);
    n_cmp++; if (bus.mode_state !== 2'd0 || bus.stop_watch_en !== 1'b0) begin
      n_bad++; $display("FAIL ack_collide_exit got mode=%0d en=%b exp 0/0", bus.mode_state, bus.stop_watch_en); end
    clear_counts();
    bus.stop_watch_ack_flag = 1'b0; bus.inc_btn_raw = 1'b0; run(4);
    n_cmp++; if (bus.mode_state !== 2'd0 || bus.menu_sel !== 2'd2 || cnt_ib !== 0) begin
      n_bad++; $display("FAIL ack_collide_after got mode=%0d menu=%0d inc=%0d exp 0/2/0", bus.mode_state, bus.menu_sel, cnt_ib); end
  endtask

  task automatic test_reset_mid();
    press_mode(2);
    press_inc(2);
    n_cmp++; if (bus.mode_state !== 2'd1) begin n_bad++; $display("FAIL enter_ts2 got=%0d exp=1", bus.mode_state); end
    bus.mode_btn_raw = 1'b1; run(3);
    rst = 1'b1; bus.mode_btn_raw = 1'b0; run(1);
    n_cmp++; if ({bus.mode_state, bus.menu_sel, bus.time_set_en, bus.alarm_set_en, bus.stop_watch_en,
                  bus.mode_button, bus.inc_button, bus.abort_pulse} !== 10'd0) begin
      n_bad++; $display("FAIL reset_mid got mode=%0d menu=%0d en=%b%b%b pulses=%b%b%b exp all 0", bus.mode_state, bus.menu_sel,
                        bus.time_set_en, bus.alarm_set_en, bus.stop_watch_en, bus.mode_button, bus.inc_button, bus.abort_pulse); end
    rst = 1'b0; run(4);
    n_cmp++; if (bus.mode_state !== 2'd0 || bus.menu_sel !== 2'd0) begin
      n_bad++; $display("FAIL reset_mid_after got mode=%0d menu=%0d exp 0/0", bus.mode_state, bus.menu_sel); end
  endtask

  task automatic test_random(input int n);
    int md_left = 0;
    int in_left = 0;
    bit own, x_mb, x_ib, x_ab;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      own = (m_mode == 1 && bus.time_set_ack_flag) || (m_mode == 2 && bus.alarm_set_ack_flag) ||
            (m_mode == 3 && bus.stop_watch_ack_flag);
      x_mb = (m_mode != 0) && !own && e_short;
      x_ib = (m_mode != 0) && !own && !e_long && e_inc;
      x_ab = (m_mode != 0) && !own && e_long;
      n_cmp++; if (bus.mode_state !== 2'(m_mode)) begin n_bad++; $display("FAIL rnd_mode i=%0d got=%0d exp=%0d", i, bus.mode_state, m_mode); end
      n_cmp++; if (bus.menu_sel !== 2'(m_menu)) begin n_bad++; $display("FAIL rnd_menu i=%0d got=%0d exp=%0d", i, bus.menu_sel, m_menu); end
      n_cmp++; if ({bus.time_set_en, bus.alarm_set_en, bus.stop_watch_en} !== {m_mode == 1, m_mode == 2, m_mode == 3}) begin
        n_bad++; $display("FAIL rnd_en i=%0d got=%b%b%b mode=%0d", i, bus.time_set_en, bus.alarm_set_en, bus.stop_watch_en, m_mode); end
      n_cmp++; if ({bus.mode_button, bus.inc_button, bus.abort_pulse} !== {x_mb, x_ib, x_ab}) begin
        n_bad++; $display("FAIL rnd_pulse i=%0d got=%b%b%b exp=%b%b%b", i, bus.mode_button, bus.inc_button, bus.abort_pulse, x_mb, x_ib, x_ab); end
      if (md_left == 0) begin
        bus.mode_btn_raw = ~bus.mode_btn_raw;
        md_left = bus.mode_btn_raw ? $urandom_range(1, 12) : $urandom_range(1, 6);
      end
      md_left--;
      if (in_left == 0) begin
        bus.inc_btn_raw = ~bus.inc_btn_raw;
        in_left = bus.inc_btn_raw ? $urandom_range(1, 4) : $urandom_range(1, 10);
      end
      in_left--;
      bus.tick_1hz            = ($urandom_range(0, 4) == 0);
      bus.time_set_ack_flag   = ($urandom_range(0, 15) == 0);
      bus.alarm_set_ack_flag  = ($urandom_range(0, 15) == 0);
      bus.stop_watch_ack_flag = ($urandom_range(0, 15) == 0);
      rst                     = ($urandom_range(0, 999) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_1hz = 1'b0; bus.mode_btn_raw = 1'b0; bus.inc_btn_raw = 1'b0;
    bus.time_set_ack_flag = 1'b0; bus.alarm_set_ack_flag = 1'b0; bus.stop_watch_ack_flag = 1'b0;
    test_reset();
    test_menu_enter();
    test_stop_watch();
    test_abort();
    test_idle_timeout();
    test_ack_collision();
    test_reset_mid();
    test_random(4000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
